fifo_burst_reader: RTL and testbench

Read-side consumer for the asynchronous FIFO. It runs entirely in the read clock domain and pops words through the FIFO read port (`empty_o`, `rinc`, `rdata`). It re-presents those words as a valid/ready stream, using a 2-entry prefetch buffer and a `last` flag every `BURST_LEN` words. It also provides run/stop control that stops only on burst boundaries, plus a flush mode that discards the FIFO contents.

---
 rtl/fifo_burst_reader.sv | 123 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-domain burst reader: pops the async FIFO into a 2-entry prefetch buffer and streams it out with a per-burst last flag.
// Optional statistics counters (words_o, drop_o) are enabled by defining FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
  parameter int DATALEN   = 8,
  parameter int BURST_LEN = 4,
  parameter int CNTLEN    = 16
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic               empty_i,
  input  logic [DATALEN-1:0] rdata_i,
  output logic               rinc_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [DATALEN-1:0] m_data_o,
  output logic               m_last_o,
  output logic               busy_o
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [CNTLEN-1:0]  words_o,
  output logic [CNTLEN-1:0]  drop_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] PLAST = PW'(BURST_LEN - 1);

  state_t             state, state_nxt;
  logic [1:0]         count;
  logic [PW-1:0]      pcnt;
  logic [DATALEN-1:0] ent_d [2];
  logic               ent_l [2];
  logic               push, xfer, wp;

  always_comb begin
    state_nxt = state;
    rinc_o    = 1'b0;
    case (state)
      IDLE: if (en_i) state_nxt = RUN;
      RUN: begin
        // Without en_i the burst in progress is still completed.
        rinc_o = !empty_i && (count != 2'd2) && (en_i || (pcnt != '0));
        if (!en_i && (pcnt == '0) && (count == 2'd0)) state_nxt = IDLE;
      end
      FLUSH: begin
        rinc_o = !empty_i;
        if (empty_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = FLUSH;
  end

  assign m_valid_o = (count != 2'd0) && (state != FLUSH);
  assign m_data_o  = ent_d[0];
  assign m_last_o  = ent_l[0];
  assign busy_o    = (state != IDLE);

  assign push = rinc_o && (state == RUN) && !flush_i;
  assign xfer = m_valid_o && m_ready_i && !flush_i;
  // Write slot is count minus any word leaving this cycle.
  assign wp   = (count == 2'd2) || ((count == 2'd1) && !xfer);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= IDLE;
      count <= 2'd0;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (flush_i) begin
        count <= 2'd0;
        pcnt  <= '0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, xfer};
        if (push) pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      ent_d[0] <= '0;
      ent_d[1] <= '0;
      ent_l[0] <= 1'b0;
      ent_l[1] <= 1'b0;
    end else if (!flush_i) begin
      if (xfer) begin
        ent_d[0] <= ent_d[1];
        ent_l[0] <= ent_l[1];
      end
      if (push) begin
        ent_d[wp] <= rdata_i;
        ent_l[wp] <= (pcnt == PLAST);
      end
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [1:0]      drop_inc;
  logic [CNTLEN:0] drop_sum;

  // Dropped words: buffer contents cleared by flush plus any word popped but not pushed.
  assign drop_inc = (flush_i ? count : 2'd0)
                  + {1'b0, rinc_o && (flush_i || (state == FLUSH))};
  assign drop_sum = {1'b0, drop_o} + (CNTLEN + 1)'(drop_inc);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      words_o <= '0;
      drop_o  <= '0;
    end else begin
      if (xfer && (words_o != '1)) words_o <= words_o + 1'b1;
      drop_o <= drop_sum[CNTLEN] ? '1 : drop_sum[CNTLEN-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: FIFO model and stream sink around a BURST_LEN=4 instance plus a BURST_LEN=1 instance.
module tb_fifo_burst_reader;

  logic       rclk = 1'b0;
  logic       rrst = 1'b0;
  logic       en_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       m_ready_i = 1'b0;
  logic       empty_i, rinc_o, m_valid_o, m_last_o, busy_o;
  logic [7:0] rdata_i, m_data_o;

  logic       en1 = 1'b0;
  logic       empty1, rinc1, valid1, last1, busy1;
  logic [7:0] rdata1, data1;

`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] words_o, drop_o, words1, drop1;
`endif

  always #5 rclk = ~rclk;

  fifo_burst_reader #(.DATALEN(8), .BURST_LEN(4), .CNTLEN(16)) dut (
    .rclk(rclk), .rrst(rrst), .en_i(en_i), .flush_i(flush_i),
    .empty_i(empty_i), .rdata_i(rdata_i), .rinc_o(rinc_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .busy_o(busy_o)
`ifdef FIFO_BURST_READER_STATS_EN
    , .words_o(words_o), .drop_o(drop_o)
`endif
  );

  fifo_burst_reader #(.DATALEN(8), .BURST_LEN(1), .CNTLEN(16)) dut1 (
    .rclk(rclk), .rrst(rrst), .en_i(en1), .flush_i(1'b0),
    .empty_i(empty1), .rdata_i(rdata1), .rinc_o(rinc1),
    .m_valid_o(valid1), .m_ready_i(1'b1), .m_data_o(data1),
    .m_last_o(last1), .busy_o(busy1)
`ifdef FIFO_BURST_READER_STATS_EN
    , .words_o(words1), .drop_o(drop1)
`endif
  );

  // FIFO models: written by the stimulus, popped on rinc.
  logic [7:0] mem [64];
  int         wr_ptr = 0, rd_ptr = 0, underflow = 0;
  logic [7:0] mem1 [4];
  int         wr1 = 0, rd1 = 0;

  assign empty_i = (rd_ptr == wr_ptr);
  assign rdata_i = mem[rd_ptr[5:0]];
  assign empty1  = (rd1 == wr1);
  assign rdata1  = mem1[rd1[1:0]];

  always @(posedge rclk) begin
    if (rinc_o) begin
      if (empty_i) underflow <= underflow + 1;
      else rd_ptr <= rd_ptr + 1;
    end
    if (rinc1 && !empty1) rd1 <= rd1 + 1;
  end

  // Sink monitors, sampled on the falling edge.
  logic [7:0] rx_d [64];
  logic       rx_l [64];
  int         rx_n = 0, unstable = 0;
  logic       hold = 1'b0, hold_l = 1'b0;
  logic [7:0] hold_d = '0;
  logic [7:0] rx1_d [8];
  int         rx1_n = 0, rx1_last = 0;

  always @(negedge rclk) begin
    if (!rrst && !flush_i && m_valid_o && m_ready_i && rx_n < 64) begin
      rx_d[rx_n] <= m_data_o;
      rx_l[rx_n] <= m_last_o;
      rx_n <= rx_n + 1;
    end
    if (hold && m_valid_o && (m_data_o !== hold_d || m_last_o !== hold_l))
      unstable <= unstable + 1;
    hold   <= m_valid_o && !m_ready_i && !flush_i && !rrst;
    hold_d <= m_data_o;
    hold_l <= m_last_o;
    if (!rrst && valid1 && rx1_n < 8) begin
      rx1_d[rx1_n] <= data1;
      rx1_n <= rx1_n + 1;
      if (last1) rx1_last <= rx1_last + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    int base_rx, base_pop, n;

    for (int i = 0; i < 3; i++) begin
      mem1[i] = 8'(8'h60 + i);
    end
    wr1 = 3;

    // Reset with en_i high and 8 words waiting.
    #1 rrst = 1'b1;
    en_i = 1'b1;
    m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    #1;
    chk("reset_rinc", 32'(rinc_o), 32'd0);
    chk("reset_valid", 32'(m_valid_o), 32'd0);
    chk("reset_data", 32'(m_data_o), 32'd0);
    chk("reset_last", 32'(m_last_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    tick();
    tick();
    rrst = 1'b0;

    n = 0;
    while (rx_n < 8 && n < 40) begin tick(); n++; end
    chk("t1_count", 32'(rx_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", 32'(rx_d[i]), 32'(8'h10 + i));
      chk("t1_last", 32'(rx_l[i]), 32'((i == 3) || (i == 7)));
    end
    chk("t1_pops", 32'(rd_ptr), 32'd8);

    // Back-pressure: buffer fills, then ready toggles every cycle.
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
    #1;
    chk("t2_rinc_start", 32'(rinc_o), 32'd1);
    tick();
    tick();
    chk("t2_rinc_full", 32'(rinc_o), 32'd0);
    chk("t2_valid_full", 32'(m_valid_o), 32'd1);
    chk("t2_head_full", 32'(m_data_o), 32'h20);
    for (int i = 0; i < 24; i++) begin
      m_ready_i = ~m_ready_i;
      tick();
    end
    m_ready_i = 1'b1;
    n = 0;
    while (rx_n < 14 && n < 30) begin tick(); n++; end
    chk("t2_count", 32'(rx_n), 32'd14);
    for (int i = 0; i < 6; i++) begin
      chk("t2_data", 32'(rx_d[8 + i]), 32'(8'h20 + i));
      chk("t2_last", 32'(rx_l[8 + i]), 32'(i == 3));
    end
    chk("t2_pops", 32'(rd_ptr), 32'd14);
    chk("t2_stable", 32'(unstable), 32'd0);

    // Reset mid-burst: one more word buffered, burst position 3.
    m_ready_i = 1'b0;
    push(8'h30);
    tick();
    tick();
    chk("t5_pre_valid", 32'(m_valid_o), 32'd1);
    chk("t5_pre_data", 32'(m_data_o), 32'h30);
    rrst = 1'b1;
    #1;
    chk("t5_rinc", 32'(rinc_o), 32'd0);
    chk("t5_valid", 32'(m_valid_o), 32'd0);
    chk("t5_data", 32'(m_data_o), 32'd0);
    chk("t5_last", 32'(m_last_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    tick();
    en_i = 1'b0;
    m_ready_i = 1'b1;
    rrst = 1'b0;
    tick();

    // Drop en_i after the second pop of a fresh burst with 10 words queued.
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    base_rx = rx_n;
    base_pop = rd_ptr;
    en_i = 1'b1;
    n = 0;
    while (rd_ptr - base_pop < 2 && n < 10) begin tick(); n++; end
    chk("t3_two_pops", 32'(rd_ptr - base_pop), 32'd2);
    en_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin tick(); n++; end
    tick();
    tick();
    chk("t3_count", 32'(rx_n - base_rx), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_data", 32'(rx_d[base_rx + i]), 32'(8'h40 + i));
      chk("t3_last", 32'(rx_l[base_rx + i]), 32'(i == 3));
    end
    chk("t3_busy", 32'(busy_o), 32'd0);
    chk("t3_left", 32'(wr_ptr - rd_ptr), 32'd6);

    // Flush with a full buffer and 5 words left in the FIFO.
    m_ready_i = 1'b0;
    push(8'h50);
    en_i = 1'b1;
    n = 0;
    while (!(m_valid_o && !rinc_o) && n < 10) begin tick(); n++; end
    chk("t4_left", 32'(wr_ptr - rd_ptr), 32'd5);
    chk("t4_head", 32'(m_data_o), 32'h44);
    en_i = 1'b0;
    flush_i = 1'b1;
    base_pop = rd_ptr;
    base_rx = rx_n;
    tick();
    flush_i = 1'b0;
    chk("t4_valid", 32'(m_valid_o), 32'd0);
    chk("t4_busy_flush", 32'(busy_o), 32'd1);
    n = 0;
    while (busy_o && n < 20) begin tick(); n++; end
    chk("t4_pops", 32'(rd_ptr - base_pop), 32'd5);
    chk("t4_empty", 32'(empty_i), 32'd1);
    chk("t4_idle", 32'(busy_o), 32'd0);
    chk("t4_no_xfer", 32'(rx_n - base_rx), 32'd0);
`ifdef FIFO_BURST_READER_STATS_EN
    chk("t4_drop", 32'(drop_o), 32'd7);
    chk("t4_words", 32'(words_o), 32'd4);
`endif
    chk("underflow", 32'(underflow), 32'd0);

    // BURST_LEN=1 instance: every word is last.
    en1 = 1'b1;
    n = 0;
    while (rx1_n < 3 && n < 20) begin tick(); n++; end
    tick();
    tick();
    chk("t6_count", 32'(rx1_n), 32'd3);
    chk("t6_lasts", 32'(rx1_last), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t6_data", 32'(rx1_d[i]), 32'(8'h60 + i));
    end
`ifdef FIFO_BURST_READER_STATS_EN
    chk("t6_words", 32'(words1), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
